// File: rtl/axi4lite_master_adapter_if.sv
// AXI4-Lite channel bundle between the native-command bridge (master) and the interconnect (slave).
// Carries the AW/W/B/AR/R channels only; clock and reset remain plain ports of the modules.
interface axi4lite_master_adapter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4lite_master_adapter.sv
// Native single-command to AXI4-Lite master bridge, one transaction in flight.
// Every AXI output is decoded from registered state only, so no AXI input reaches an AXI output.
module axi4lite_master_adapter #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi4lite_master_adapter_if.master m_axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  logic awvalid, wvalid, bready, arvalid, rready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_we ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done_d && w_done_d) state_d = WR_RESP;
      WR_RESP: if (m_axi.bvalid) state_d = RSP;
      RD_REQ:  if (m_axi.arready) state_d = RD_DATA;
      RD_DATA: if (m_axi.rvalid) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      WR_REQ: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      WR_RESP: bready    = 1'b1;
      RD_REQ:  arvalid   = 1'b1;
      RD_DATA: rready    = 1'b1;
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command capture, per-channel done tracking and response capture
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (cmd_valid && cmd_ready) begin
      addr_d    = cmd_addr;
      wdata_d   = cmd_wdata;
      be_d      = cmd_be;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
    if (awvalid && m_axi.awready) aw_done_d = 1'b1;
    if (wvalid && m_axi.wready)   w_done_d  = 1'b1;
    if (bready && m_axi.bvalid) begin
      resp_d  = m_axi.bresp;
      rdata_d = '0;
    end
    if (rready && m_axi.rvalid) begin
      resp_d  = m_axi.rresp;
      rdata_d = m_axi.rdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = PROT;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = be_q;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = PROT;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_axi4lite_master_adapter.sv
// Bench for axi4lite_master_adapter: directed vector table driven through a delay-programmable AXI slave,
// plus reset-mid-transaction and back-to-back stream sequences.
module tb_axi4lite_master_adapter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  always #5 aclk = ~aclk;

  axi4lite_master_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

  axi4lite_master_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_be    (cmd_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .m_axi     (m_if)
  );

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] be;
    int            aw_dly;
    int            w_dly;
    int            b_dly;
    int            ar_dly;
    int            r_dly;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_resp;
    int            rsp_hold;
    bit            chk_lat;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave configuration and observation counters
  int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_resp = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [SW-1:0] exp_be = '0;
  int            aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int            aw_cyc = 0, w_cyc = 0, ar_cyc = 0;

  initial begin
    bit            p_aw, p_w, p_b, p_ar, p_r;
    bit            aw_got, w_got, ar_got;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit            prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr;
    logic [AW-1:0] prev_awaddr, prev_araddr;
    logic [DW-1:0] prev_wdata;
    logic [SW-1:0] prev_wstrb;
    m_if.awready = 1'b0;
    m_if.wready  = 1'b0;
    m_if.bvalid  = 1'b0;
    m_if.bresp   = '0;
    m_if.arready = 1'b0;
    m_if.rvalid  = 1'b0;
    m_if.rdata   = '0;
    m_if.rresp   = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0;
        m_if.arready = 1'b0; m_if.rvalid = 1'b0;
        {p_aw, p_w, p_b, p_ar, p_r} = '0;
        {aw_got, w_got, ar_got} = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        {prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr} = '0;
      end else begin
        // A valid still waiting for its ready must stay up with unchanged payload
        if (prev_awv && !prev_awr) begin
          check("awvalid hold", m_if.awvalid, 1'b1);
          check("awaddr stable", m_if.awaddr, prev_awaddr);
        end
        if (prev_wv && !prev_wr) begin
          check("wvalid hold", m_if.wvalid, 1'b1);
          check("wdata/wstrb stable", {m_if.wdata, m_if.wstrb}, {prev_wdata, prev_wstrb});
        end
        if (prev_arv && !prev_arr) begin
          check("arvalid hold", m_if.arvalid, 1'b1);
          check("araddr stable", m_if.araddr, prev_araddr);
        end
        if (p_aw) begin aw_got = 1'b1; m_if.awready = 1'b0; aw_cnt = 0; end
        if (p_w)  begin w_got = 1'b1;  m_if.wready = 1'b0;  w_cnt = 0;  end
        if (p_b)  m_if.bvalid = 1'b0;
        if (p_ar) begin ar_got = 1'b1; m_if.arready = 1'b0; ar_cnt = 0; end
        if (p_r)  m_if.rvalid = 1'b0;
        if (m_if.awvalid) aw_cyc++;
        if (m_if.wvalid)  w_cyc++;
        if (m_if.arvalid) ar_cyc++;
        if (m_if.awvalid && !m_if.awready) begin
          if (aw_cnt >= aw_dly) m_if.awready = 1'b1; else aw_cnt++;
        end
        if (m_if.wvalid && !m_if.wready) begin
          if (w_cnt >= w_dly) m_if.wready = 1'b1; else w_cnt++;
        end
        if (m_if.arvalid && !m_if.arready) begin
          if (ar_cnt >= ar_dly) m_if.arready = 1'b1; else ar_cnt++;
        end
        if (aw_got && w_got && !m_if.bvalid) begin
          if (b_cnt >= b_dly) begin
            m_if.bvalid = 1'b1; m_if.bresp = s_resp;
            aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
          end else b_cnt++;
        end
        if (ar_got && !m_if.rvalid) begin
          if (r_cnt >= r_dly) begin
            m_if.rvalid = 1'b1; m_if.rdata = s_rdata; m_if.rresp = s_resp;
            ar_got = 1'b0; r_cnt = 0;
          end else r_cnt++;
        end
        p_aw = m_if.awvalid && m_if.awready;
        p_w  = m_if.wvalid && m_if.wready;
        p_b  = m_if.bvalid && m_if.bready;
        p_ar = m_if.arvalid && m_if.arready;
        p_r  = m_if.rvalid && m_if.rready;
        if (p_aw) begin
          aw_hs_n++;
          check("awaddr/awprot", {m_if.awaddr, m_if.awprot}, {exp_addr, 3'b000});
        end
        if (p_w) begin
          w_hs_n++;
          check("wdata/wstrb", {m_if.wdata, m_if.wstrb}, {exp_wdata, exp_be});
        end
        if (p_b) b_hs_n++;
        if (p_ar) begin
          ar_hs_n++;
          check("araddr/arprot", {m_if.araddr, m_if.arprot}, {exp_addr, 3'b000});
        end
        if (p_r) r_hs_n++;
        prev_awv = m_if.awvalid; prev_awr = m_if.awready; prev_awaddr = m_if.awaddr;
        prev_wv  = m_if.wvalid;  prev_wr  = m_if.wready;
        prev_wdata = m_if.wdata; prev_wstrb = m_if.wstrb;
        prev_arv = m_if.arvalid; prev_arr = m_if.arready; prev_araddr = m_if.araddr;
      end
    end
  end

  task automatic nxt();
    @(negedge aclk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int            n;
    int            a0, w0, b0, ar0, r0, awc0, wc0, arc0;
    bit            busy_ok, stable;
    logic [DW-1:0] hold_d;
    logic [1:0]    hold_r;
    aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly;
    ar_dly = v.ar_dly; r_dly = v.r_dly;
    s_rdata = v.s_rdata; s_resp = v.s_resp;
    exp_addr = v.addr; exp_wdata = v.wdata; exp_be = v.be;
    n = 0;
    while (!cmd_ready && n < 50) begin nxt(); n++; end
    check({tag, " cmd_ready before issue"}, cmd_ready, 1'b1);
    a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; ar0 = ar_hs_n; r0 = r_hs_n;
    awc0 = aw_cyc; wc0 = w_cyc; arc0 = ar_cyc;
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_be = v.be;
    nxt();
    cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_be = ~v.be;
    n = 1;
    busy_ok = 1'b1;
    while (!rsp_valid && n < 100) begin
      if (cmd_ready) busy_ok = 1'b0;
      nxt();
      n++;
    end
    check({tag, " rsp_valid arrives"}, rsp_valid, 1'b1);
    check({tag, " cmd_ready low while busy"}, busy_ok, 1'b1);
    if (v.chk_lat) check({tag, " rsp latency"}, n, 3);
    hold_d = rsp_rdata;
    hold_r = rsp_resp;
    stable = 1'b1;
    for (int i = 0; i < v.rsp_hold; i++) begin
      nxt();
      if (!rsp_valid || rsp_rdata !== hold_d || rsp_resp !== hold_r || cmd_ready) stable = 1'b0;
    end
    if (v.rsp_hold > 0) check({tag, " rsp held stable"}, stable, 1'b1);
    check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, " rsp_resp"}, rsp_resp, v.exp_resp);
    rsp_ready = 1'b1;
    nxt();
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop / cmd_ready back"}, {rsp_valid, cmd_ready}, 2'b01);
    check({tag, " handshake counts aw,w,b,ar,r"},
          {4'(aw_hs_n - a0), 4'(w_hs_n - w0), 4'(b_hs_n - b0), 4'(ar_hs_n - ar0), 4'(r_hs_n - r0)},
          v.we ? 20'h11100 : 20'h00011);
    if (v.we) begin
      check({tag, " awvalid cycles"}, aw_cyc - awc0, v.aw_dly + 1);
      check({tag, " wvalid cycles"}, w_cyc - wc0, v.w_dly + 1);
    end else begin
      check({tag, " arvalid cycles"}, ar_cyc - arc0, v.ar_dly + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int   n;
    bit   quiet;
    vecs[0] = '{we:1, addr:32'h10, wdata:32'hDEADBEEF, be:4'hF, aw_dly:0, w_dly:0, b_dly:0, ar_dly:0, r_dly:0,
                s_rdata:32'h0, s_resp:2'b00, rsp_hold:0, chk_lat:1, exp_rdata:32'h0, exp_resp:2'b00};
    vecs[1] = '{we:1, addr:32'h20, wdata:32'hCAFEF00D, be:4'h3, aw_dly:3, w_dly:0, b_dly:0, ar_dly:0, r_dly:0,
                s_rdata:32'h0, s_resp:2'b00, rsp_hold:0, chk_lat:0, exp_rdata:32'h0, exp_resp:2'b00};
    vecs[2] = '{we:0, addr:32'h24, wdata:32'h0, be:4'h0, aw_dly:0, w_dly:0, b_dly:0, ar_dly:0, r_dly:5,
                s_rdata:32'h12345678, s_resp:2'b00, rsp_hold:0, chk_lat:0, exp_rdata:32'h12345678, exp_resp:2'b00};
    vecs[3] = '{we:1, addr:32'h30, wdata:32'h01020304, be:4'hF, aw_dly:0, w_dly:0, b_dly:1, ar_dly:0, r_dly:0,
                s_rdata:32'h0, s_resp:2'b10, rsp_hold:4, chk_lat:0, exp_rdata:32'h0, exp_resp:2'b10};
    vecs[4] = '{we:0, addr:32'h44, wdata:32'h0, be:4'h0, aw_dly:0, w_dly:0, b_dly:0, ar_dly:2, r_dly:1,
                s_rdata:32'hA5A50F0F, s_resp:2'b11, rsp_hold:1, chk_lat:0, exp_rdata:32'hA5A50F0F, exp_resp:2'b11};
    vecs[5] = '{we:1, addr:32'h48, wdata:32'h0BADF00D, be:4'hC, aw_dly:0, w_dly:2, b_dly:2, ar_dly:0, r_dly:0,
                s_rdata:32'h0, s_resp:2'b01, rsp_hold:0, chk_lat:0, exp_rdata:32'h0, exp_resp:2'b01};
    vecs[6] = '{we:0, addr:32'h4C, wdata:32'h0, be:4'h0, aw_dly:0, w_dly:0, b_dly:0, ar_dly:0, r_dly:0,
                s_rdata:32'hFFFFFFFF, s_resp:2'b00, rsp_hold:0, chk_lat:1, exp_rdata:32'hFFFFFFFF, exp_resp:2'b00};

    // Reset state
    nxt();
    nxt();
    check("reset valids/readies", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready, rsp_valid}, 6'b0);
    check("reset rsp regs", {rsp_rdata, rsp_resp}, 34'h0);
    check("reset addr/data regs", {m_if.awaddr, m_if.wdata, m_if.wstrb}, 68'h0);
    aresetn = 1'b1;
    nxt();
    check("cmd_ready after reset", cmd_ready, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while AW/W are pending
    aw_dly = 20; w_dly = 20; exp_addr = 32'h88; exp_wdata = 32'h11112222; exp_be = 4'hF;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h88; cmd_wdata = 32'h11112222; cmd_be = 4'hF;
    nxt();
    cmd_valid = 1'b0;
    nxt();
    check("rst-mid awvalid before pulse", m_if.awvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("rst-mid valids drop async",
          {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready, rsp_valid}, 6'b0);
    nxt();
    aresetn = 1'b1;
    nxt();
    check("rst-mid cmd_ready after release", {cmd_ready, m_if.awvalid, m_if.wvalid}, 3'b100);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      if (rsp_valid || m_if.awvalid || m_if.wvalid || !cmd_ready) quiet = 1'b0;
    end
    check("rst-mid no response afterwards", quiet, 1'b1);
    run_vec(vecs[0], "post-reset write");

    // Back-to-back W, R, W with random slave backpressure
    for (int k = 0; k < 3; k++) begin
      rv.we       = (k != 1);
      rv.addr     = 32'h100 + 32'(k * 4);
      rv.wdata    = $urandom;
      rv.be       = 4'($urandom_range(1, 15));
      rv.aw_dly   = $urandom_range(0, 3);
      rv.w_dly    = $urandom_range(0, 3);
      rv.b_dly    = $urandom_range(0, 3);
      rv.ar_dly   = $urandom_range(0, 3);
      rv.r_dly    = $urandom_range(0, 3);
      rv.s_rdata  = $urandom;
      rv.s_resp   = 2'($urandom_range(0, 3));
      rv.rsp_hold = $urandom_range(0, 2);
      rv.chk_lat  = 1'b0;
      rv.exp_rdata = rv.we ? 32'h0 : rv.s_rdata;
      rv.exp_resp  = rv.s_resp;
      run_vec(rv, $sformatf("b2b%0d", k));
    end

    n = 0;
    while (n < 3) begin nxt(); n++; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
